// File: rtl/pc_pkg.sv
// Shared constants and operation select for the program-counter sequencer.
// Default sizes plus the priority-decoder helper.
package pc_pkg;

    localparam int AW_DEF       = 8;
    localparam int DEPTH_DEF    = 4;
    localparam int RST_ADDR_DEF = 0;

    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_INC    = 3'd1,
        OP_BRANCH = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4
    } op_e;

    // RET > CALL > BRANCH > INC > hold; reset is handled by the caller.
    function automatic op_e decode_op(
        input logic inc,
        input logic branch,
        input logic call,
        input logic ret
    );
        op_e op;
        op = OP_HOLD;
        if (ret) begin
            op = OP_RET;
        end else if (call) begin
            op = OP_CALL;
        end else if (branch) begin
            op = OP_BRANCH;
        end else if (inc) begin
            op = OP_INC;
        end
        return op;
    endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Request/status bundle between a sequencer client and pc_seq.
// The client drives the requests, the sequencer drives address and stack status.
interface pc_seq_if
    import pc_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
);

    localparam int SPW = $clog2(DEPTH + 1);

    logic          INC;
    logic          BRANCH;
    logic          CALL;
    logic          RET;
    logic [AW-1:0] addr_in;

    logic [AW-1:0]  addr_out;
    logic [SPW-1:0] sp;
    logic           stk_full;
    logic           stk_empty;
    logic           stk_err;

    modport master (
        output INC, BRANCH, CALL, RET, addr_in,
        input  addr_out, sp, stk_full, stk_empty, stk_err
    );

    modport slave (
        input  INC, BRANCH, CALL, RET, addr_in,
        output addr_out, sp, stk_full, stk_empty, stk_err
    );

endinterface

// File: rtl/ras_lifo.sv
// Return-address stack: entry storage, entry count and full/empty flags.
// Flags are registered from the next count so they never lag sp.
module ras_lifo #(
    parameter int AW    = 8,
    parameter int DEPTH = 4,
    localparam int SPW  = $clog2(DEPTH + 1),
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic           pop,
    input  logic [AW-1:0]  push_data,
    output logic [AW-1:0]  top_data,
    output logic [SPW-1:0] sp,
    output logic           full,
    output logic           empty
);

    logic [AW-1:0]  mem_q [DEPTH];
    logic [SPW-1:0] sp_q;
    logic [SPW-1:0] sp_d;
    logic [SPW-1:0] sp_m1;
    logic           full_q;
    logic           full_d;
    logic           empty_q;
    logic           empty_d;
    logic [IW-1:0]  wr_idx;
    logic [IW-1:0]  rd_idx;
    logic           do_push;
    logic           do_pop;

    // Next count and flags; pop wins if both are ever requested together.
    always_comb begin
        sp_m1   = sp_q - SPW'(1);
        wr_idx  = sp_q[IW-1:0];
        rd_idx  = sp_m1[IW-1:0];
        do_pop  = pop && !empty_q;
        do_push = push && !full_q && !do_pop;
        sp_d    = sp_q;
        if (rst) begin
            sp_d = '0;
        end else if (do_pop) begin
            sp_d = sp_m1;
        end else if (do_push) begin
            sp_d = sp_q + SPW'(1);
        end
        full_d  = (sp_d == SPW'(DEPTH));
        empty_d = (sp_d == '0);
    end

    // Count and flag registers.
    always_ff @(posedge clk) begin
        sp_q    <= sp_d;
        full_q  <= full_d;
        empty_q <= empty_d;
    end

    // Entry storage is never cleared; it is unreachable once sp is zero.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_idx] <= push_data;
        end
    end

    assign top_data = mem_q[rd_idx];
    assign sp       = sp_q;
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer with increment, branch, call and return.
// Owns the priority decode, the address register and the sticky error flag.
module pc_seq
    import pc_pkg::*;
#(
    parameter int            AW       = AW_DEF,
    parameter int            DEPTH    = DEPTH_DEF,
    parameter logic [AW-1:0] RST_ADDR = AW'(RST_ADDR_DEF)
) (
    input  logic    clk,
    input  logic    RST,
    pc_seq_if.slave bus
);

    localparam int SPW = $clog2(DEPTH + 1);

    op_e            op;
    logic [AW-1:0]  addr_q;
    logic [AW-1:0]  addr_d;
    logic [AW-1:0]  addr_inc;
    logic           err_q;
    logic           err_d;
    logic           push;
    logic           pop;
    logic [AW-1:0]  top_data;
    logic [SPW-1:0] sp;
    logic           full;
    logic           empty;

    // Select one operation and work out the next address and error state.
    always_comb begin
        op       = decode_op(bus.INC, bus.BRANCH, bus.CALL, bus.RET);
        addr_inc = addr_q + AW'(1);
        addr_d   = addr_q;
        err_d    = err_q;
        push     = 1'b0;
        pop      = 1'b0;
        unique case (op)
            OP_INC: begin
                addr_d = addr_inc;
            end
            OP_BRANCH: begin
                addr_d = bus.addr_in;
            end
            OP_CALL: begin
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    push   = 1'b1;
                    addr_d = bus.addr_in;
                end
            end
            OP_RET: begin
                if (empty) begin
                    err_d = 1'b1;
                end else begin
                    pop    = 1'b1;
                    addr_d = top_data;
                end
            end
            default: begin
                addr_d = addr_q;
            end
        endcase
        if (RST) begin
            push = 1'b0;
            pop  = 1'b0;
        end
    end

    // Address and sticky error registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (RST) begin
            addr_q <= RST_ADDR;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end

    ras_lifo #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (RST),
        .push      (push),
        .pop       (pop),
        .push_data (addr_inc),
        .top_data  (top_data),
        .sp        (sp),
        .full      (full),
        .empty     (empty)
    );

    assign bus.addr_out  = addr_q;
    assign bus.sp        = sp;
    assign bus.stk_full  = full;
    assign bus.stk_empty = empty;
    assign bus.stk_err   = err_q;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: directed scenarios plus random traffic.
// A queue-based stack model predicts every cycle's outputs.
module tb_pc_seq;

    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam logic [AW-1:0] RA = 8'h00;

    typedef struct {
        int addr;
        int sp;
        bit full;
        bit empty;
        bit err;
    } exp_t;

    logic clk;
    logic rst;

    int tests;
    int fails;

    exp_t exp_q[$];

    int m_addr;
    int m_stk[$];
    bit m_err;

    pc_seq_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

    pc_seq #(
        .AW       (AW),
        .DEPTH    (DEPTH),
        .RST_ADDR (RA)
    ) dut (
        .clk (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of requests at the current negedge, predict, wait.
    task automatic step(
        input bit r,
        input bit i,
        input bit b,
        input bit c,
        input bit t,
        input int a
    );
        exp_t e;
        rst         = r;
        bus.INC     = i;
        bus.BRANCH  = b;
        bus.CALL    = c;
        bus.RET     = t;
        bus.addr_in = a[AW-1:0];
        if (r) begin
            m_addr = int'(RA);
            m_stk.delete();
            m_err = 1'b0;
        end else if (t) begin
            if (m_stk.size() > 0) m_addr = m_stk.pop_back();
            else m_err = 1'b1;
        end else if (c) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back((m_addr + 1) % 256);
                m_addr = a % 256;
            end else begin
                m_err = 1'b1;
            end
        end else if (b) begin
            m_addr = a % 256;
        end else if (i) begin
            m_addr = (m_addr + 1) % 256;
        end
        e.addr  = m_addr;
        e.sp    = m_stk.size();
        e.full  = (m_stk.size() == DEPTH);
        e.empty = (m_stk.size() == 0);
        e.err   = m_err;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic lit(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Monitor: one scoreboard entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (int'(bus.addr_out) != e.addr || int'(bus.sp) != e.sp ||
                    bus.stk_full != e.full || bus.stk_empty != e.empty ||
                    bus.stk_err != e.err) begin
                    fails++;
                    $display("FAIL cycle @%0t: got addr=%0h sp=%0d f=%0b e=%0b err=%0b want addr=%0h sp=%0d f=%0b e=%0b err=%0b",
                             $time, bus.addr_out, bus.sp, bus.stk_full,
                             bus.stk_empty, bus.stk_err, e.addr, e.sp,
                             e.full, e.empty, e.err);
                end
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        m_addr = 0;
        m_err = 1'b0;
        rst = 1'b1;
        bus.INC = 1'b0;
        bus.BRANCH = 1'b0;
        bus.CALL = 1'b0;
        bus.RET = 1'b0;
        bus.addr_in = '0;
        @(negedge clk);

        // Reset then 260 increments with wrap.
        step(1, 0, 0, 0, 0, 0);
        lit("rst_addr", int'(bus.addr_out), 0);
        lit("rst_empty", int'(bus.stk_empty), 1);
        lit("rst_err", int'(bus.stk_err), 0);
        for (int k = 0; k < 256; k++) step(0, 1, 0, 0, 0, 0);
        lit("inc_wrap", int'(bus.addr_out), 0);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0, 0);
        lit("inc_end", int'(bus.addr_out), 4);
        lit("inc_empty", int'(bus.stk_empty), 1);

        // Nested calls and returns.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 'h10);
        step(0, 0, 0, 1, 0, 'h40);
        lit("call1", int'(bus.addr_out), 'h40);
        step(0, 0, 0, 1, 0, 'h80);
        lit("call2", int'(bus.addr_out), 'h80);
        lit("call2_sp", int'(bus.sp), 2);
        step(0, 0, 0, 0, 1, 0);
        lit("ret1", int'(bus.addr_out), 'h41);
        step(0, 0, 0, 0, 1, 0);
        lit("ret2", int'(bus.addr_out), 'h11);
        lit("ret2_sp", int'(bus.sp), 0);

        // Overflow.
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0, 'h20);
        lit("ovf_full", int'(bus.stk_full), 1);
        lit("ovf_err0", int'(bus.stk_err), 0);
        step(0, 0, 0, 1, 0, 'h20);
        lit("ovf_addr", int'(bus.addr_out), 'h20);
        lit("ovf_sp", int'(bus.sp), 4);
        lit("ovf_err", int'(bus.stk_err), 1);
        step(0, 0, 0, 0, 1, 0);
        lit("ovf_ret", int'(bus.addr_out), 'h21);

        // Underflow and priority.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        lit("unf_addr", int'(bus.addr_out), 0);
        lit("unf_err", int'(bus.stk_err), 1);
        step(0, 0, 1, 0, 0, 'h05);
        step(0, 1, 1, 1, 0, 'h30);
        lit("pri_addr", int'(bus.addr_out), 'h30);
        lit("pri_sp", int'(bus.sp), 1);
        step(0, 0, 0, 1, 1, 'h77);
        lit("retcall", int'(bus.addr_out), 'h06);
        lit("retcall_sp", int'(bus.sp), 0);

        // Reset mid-operation.
        step(0, 0, 0, 1, 0, 'h50);
        step(0, 0, 0, 1, 0, 'h60);
        step(0, 0, 0, 1, 0, 'h70);
        lit("mid_sp", int'(bus.sp), 3);
        step(1, 0, 0, 1, 0, 'h90);
        lit("mid_addr", int'(bus.addr_out), int'(RA));
        lit("mid_sp0", int'(bus.sp), 0);
        lit("mid_err", int'(bus.stk_err), 0);
        lit("mid_empty", int'(bus.stk_empty), 1);

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 1) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 255)));
        end

        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        lit("drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
